// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Round-robin burst arbiter. It grants one of NUM_REQ write
//                requesters ownership of a single FIFO write port for up to
//                MAX_BURST beats. Data passes through with zero latency.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            grant,
   input  logic                          fifo_full,
   output logic                          fifo_wrt_en,
   output logic [DATA_WIDTH-1:0]         fifo_data_wrt,
   output logic                          busy
);

   localparam int                IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int                CNT_W       = $clog2(MAX_BURST) + 1;
   localparam logic [IDX_W-1:0]  c_LAST_IDX  = IDX_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0]  c_MAX_BEATS = CNT_W'(MAX_BURST);
   localparam logic [NUM_REQ-1:0] c_ONE_HOT0 = NUM_REQ'(1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   state_t               r_state;
   logic [NUM_REQ-1:0]   r_grant;
   logic [IDX_W-1:0]     r_owner;
   logic [IDX_W-1:0]     r_rr_ptr;
   logic [CNT_W-1:0]     r_beat_cnt;

   logic                 w_pick_found;
   logic [IDX_W-1:0]     w_pick_idx;
   logic                 w_in_burst;
   logic                 w_owner_valid;
   logic                 w_owner_last;
   logic [DATA_WIDTH-1:0] w_owner_data;
   logic                 w_beat;
   logic                 w_release;
   logic [IDX_W-1:0]     w_next_ptr;

   // Round-robin search: first valid requester at or above rr_ptr, wrapping.
   always_comb begin
      int j;
      w_pick_found = 1'b0;
      w_pick_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(r_rr_ptr) + k;
         if (j >= NUM_REQ) begin
            j = j - NUM_REQ;
         end
         if (!w_pick_found && req_valid[j[IDX_W-1:0]]) begin
            w_pick_found = 1'b1;
            w_pick_idx   = j[IDX_W-1:0];
         end
      end
   end

   // Select the current owner's data slice from the one-hot grant.
   always_comb begin
      w_owner_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_grant[i]) begin
            w_owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign w_in_burst    = (r_state == ST_BURST);
   assign w_owner_valid = |(r_grant & req_valid);
   assign w_owner_last  = |(r_grant & req_last);

   // rst_n gates the write path directly so a reset mid-beat kills the write
   // in the same cycle, without waiting on the state register.
   assign w_beat    = w_in_burst && w_owner_valid && !fifo_full && rst_n;
   assign w_release = w_in_burst &&
                      (!w_owner_valid ||
                       (w_beat && (w_owner_last ||
                                   ((r_beat_cnt + CNT_W'(1)) == c_MAX_BEATS))));
   assign w_next_ptr = (r_owner == c_LAST_IDX) ? '0 : (r_owner + IDX_W'(1));

   assign req_ready     = r_grant & {NUM_REQ{w_in_burst && !fifo_full && rst_n}};
   assign fifo_wrt_en   = w_beat;
   assign fifo_data_wrt = w_beat ? w_owner_data : '0;
   assign grant         = r_grant;
   assign busy          = w_in_burst;

   // Arbitration FSM: grant in IDLE, count beats and release in BURST.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_grant    <= '0;
         r_owner    <= '0;
         r_rr_ptr   <= '0;
         r_beat_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pick_found) begin
                  r_state    <= ST_BURST;
                  r_grant    <= c_ONE_HOT0 << w_pick_idx;
                  r_owner    <= w_pick_idx;
                  r_beat_cnt <= '0;
               end
            end
            ST_BURST: begin
               if (w_beat) begin
                  r_beat_cnt <= r_beat_cnt + CNT_W'(1);
               end
               if (w_release) begin
                  r_state  <= ST_IDLE;
                  r_grant  <= '0;
                  r_rr_ptr <= w_next_ptr;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_grant <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_arbiter
//  Description : Directed self-checking bench for fifo_wr_arbiter
//                (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_wr_arbiter;

   localparam int NUM_REQ    = 4;
   localparam int DATA_WIDTH = 8;
   localparam int MAX_BURST  = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic [3:0]  grant;
   logic        fifo_full;
   logic        fifo_wrt_en;
   logic [7:0]  fifo_data_wrt;
   logic        busy;

   int checks = 0;
   int errors = 0;

   // Observed output bundle: {busy, fifo_wrt_en, grant, req_ready, fifo_data_wrt}
   wire [17:0] obs = {busy, fifo_wrt_en, grant, req_ready, fifo_data_wrt};

   fifo_wr_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .DATA_WIDTH (DATA_WIDTH),
      .MAX_BURST  (MAX_BURST)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .grant         (grant),
      .fifo_full     (fifo_full),
      .fifo_wrt_en   (fifo_wrt_en),
      .fifo_data_wrt (fifo_data_wrt),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [17:0] exp;
      rst_n     = 1'b1;
      req_valid = 4'b1111;
      req_last  = 4'b0000;
      fifo_full = 1'b0;
      req_data  = 32'h3322_1100;
      #1 rst_n = 1'b0;
      #2;
      exp = 18'h0;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset_async: got %h expected %h", obs, exp); end
      tick();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset_held: got %h expected %h", obs, exp); end
      req_valid = 4'b0000;
      rst_n     = 1'b1;
   endtask

   task automatic test_max_burst();
      logic [17:0] exp;
      logic [7:0]  d;
      req_valid = 4'b1010;
      req_data[8 +: 8]  = 8'h10;
      req_data[24 +: 8] = 8'h31;
      @(negedge clk);
      exp = 18'h0;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL max_idle_pre: got %h expected %h", obs, exp); end
      tick();
      for (int b = 0; b < 4; b++) begin
         d = 8'(8'h10 + b);
         req_data[8 +: 8] = d;
         @(negedge clk);
         exp = {1'b1, 1'b1, 4'b0010, 4'b0010, d};
         checks++;
         if (obs !== exp) begin errors++; $display("FAIL max_beat%0d: got %h expected %h", b, obs, exp); end
         tick();
      end
      @(negedge clk);
      exp = 18'h0;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL max_idle_post: got %h expected %h", obs, exp); end
      tick();
      @(negedge clk);
      exp = {1'b1, 1'b1, 4'b1000, 4'b1000, 8'h31};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL max_regrant3: got %h expected %h", obs, exp); end
      tick();
      req_valid = 4'b0000;
      @(negedge clk);
      exp = {1'b1, 1'b0, 4'b1000, 4'b1000, 8'h00};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL max_abandon: got %h expected %h", obs, exp); end
      tick();
   endtask

   task automatic test_last_beat();
      logic [17:0] exp;
      req_valid = 4'b0001;
      req_last  = 4'b0000;
      req_data[0 +: 8] = 8'hA1;
      @(negedge clk);
      exp = 18'h0;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL last_idle: got %h expected %h", obs, exp); end
      tick();
      @(negedge clk);
      exp = {1'b1, 1'b1, 4'b0001, 4'b0001, 8'hA1};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL last_beat1: got %h expected %h", obs, exp); end
      tick();
      req_data[0 +: 8] = 8'hA2;
      req_last = 4'b0001;
      @(negedge clk);
      exp = {1'b1, 1'b1, 4'b0001, 4'b0001, 8'hA2};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL last_beat2: got %h expected %h", obs, exp); end
      tick();
      req_valid = 4'b1111;
      req_last  = 4'b0000;
      req_data  = 32'h4433_2211;
      @(negedge clk);
      exp = 18'h0;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL last_busy_falls: got %h expected %h", obs, exp); end
      tick();
      @(negedge clk);
      exp = {1'b1, 1'b1, 4'b0010, 4'b0010, 8'h22};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL last_rr_ptr1: got %h expected %h", obs, exp); end
      tick();
      req_valid = 4'b0000;
      @(negedge clk);
      exp = {1'b1, 1'b0, 4'b0010, 4'b0010, 8'h00};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL last_abandon: got %h expected %h", obs, exp); end
      tick();
   endtask

   task automatic test_stall();
      logic [17:0] exp;
      logic [7:0]  d;
      req_valid = 4'b0100;
      req_data[16 +: 8] = 8'h20;
      @(negedge clk);
      exp = 18'h0;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL stall_idle: got %h expected %h", obs, exp); end
      tick();
      @(negedge clk);
      exp = {1'b1, 1'b1, 4'b0100, 4'b0100, 8'h20};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL stall_beat0: got %h expected %h", obs, exp); end
      tick();
      fifo_full = 1'b1;
      req_valid = 4'b1111;
      req_data[16 +: 8] = 8'h21;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         exp = {1'b1, 1'b0, 4'b0100, 4'b0000, 8'h00};
         checks++;
         if (obs !== exp) begin errors++; $display("FAIL stall_full%0d: got %h expected %h", s, obs, exp); end
         tick();
      end
      fifo_full = 1'b0;
      req_valid = 4'b0100;
      for (int b = 1; b < 4; b++) begin
         d = 8'(8'h20 + b);
         req_data[16 +: 8] = d;
         @(negedge clk);
         exp = {1'b1, 1'b1, 4'b0100, 4'b0100, d};
         checks++;
         if (obs !== exp) begin errors++; $display("FAIL stall_resume%0d: got %h expected %h", b, obs, exp); end
         tick();
      end
      req_valid = 4'b0000;
      @(negedge clk);
      exp = 18'h0;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL stall_release: got %h expected %h", obs, exp); end
      tick();
   endtask

   task automatic test_abandon();
      logic [17:0] exp;
      req_valid = 4'b1001;
      req_data[24 +: 8] = 8'h3A;
      req_data[0 +: 8]  = 8'h0B;
      @(negedge clk);
      exp = 18'h0;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL aband_idle_pre: got %h expected %h", obs, exp); end
      tick();
      @(negedge clk);
      exp = {1'b1, 1'b1, 4'b1000, 4'b1000, 8'h3A};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL aband_beat: got %h expected %h", obs, exp); end
      tick();
      req_valid = 4'b0001;
      @(negedge clk);
      exp = {1'b1, 1'b0, 4'b1000, 4'b1000, 8'h00};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL aband_cycle: got %h expected %h", obs, exp); end
      tick();
      @(negedge clk);
      exp = 18'h0;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL aband_idle_post: got %h expected %h", obs, exp); end
      tick();
      @(negedge clk);
      exp = {1'b1, 1'b1, 4'b0001, 4'b0001, 8'h0B};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL aband_next_grant: got %h expected %h", obs, exp); end
      tick();
      req_valid = 4'b0000;
      @(negedge clk);
      exp = {1'b1, 1'b0, 4'b0001, 4'b0001, 8'h00};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL aband_drop2: got %h expected %h", obs, exp); end
      tick();
   endtask

   task automatic test_round_robin();
      logic [17:0] exp;
      logic [3:0]  gnt;
      int          g;
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      req_valid = 4'b1111;
      req_last  = 4'b0000;
      req_data  = 32'hC3C2_C1C0;
      for (int n = 0; n < 5; n++) begin
         g   = n % 4;
         gnt = 4'b0001 << g;
         @(negedge clk);
         exp = 18'h0;
         checks++;
         if (obs !== exp) begin errors++; $display("FAIL rr_idle%0d: got %h expected %h", n, obs, exp); end
         tick();
         for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            exp = {1'b1, 1'b1, gnt, gnt, 8'(8'hC0 + g)};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL rr_n%0d_b%0d: got %h expected %h", n, b, obs, exp); end
            tick();
         end
      end
      req_valid = 4'b0000;
   endtask

   task automatic test_reset_mid_burst();
      logic [17:0] exp;
      req_valid = 4'b0010;
      req_data[8 +: 8] = 8'h51;
      @(negedge clk);
      exp = 18'h0;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL mrst_idle: got %h expected %h", obs, exp); end
      tick();
      @(negedge clk);
      exp = {1'b1, 1'b1, 4'b0010, 4'b0010, 8'h51};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL mrst_beat1: got %h expected %h", obs, exp); end
      tick();
      req_data[8 +: 8] = 8'h52;
      @(negedge clk);
      exp = {1'b1, 1'b1, 4'b0010, 4'b0010, 8'h52};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL mrst_beat2: got %h expected %h", obs, exp); end
      #1 rst_n = 1'b0;
      #1;
      exp = 18'h0;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL mrst_async: got %h expected %h", obs, exp); end
      tick();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL mrst_held: got %h expected %h", obs, exp); end
      rst_n     = 1'b1;
      req_valid = 4'b0100;
      req_data[16 +: 8] = 8'h61;
      @(negedge clk);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL mrst_post_idle: got %h expected %h", obs, exp); end
      tick();
      @(negedge clk);
      exp = {1'b1, 1'b1, 4'b0100, 4'b0100, 8'h61};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL mrst_post_grant: got %h expected %h", obs, exp); end
      tick();
      req_valid = 4'b0000;
      @(negedge clk);
      exp = {1'b1, 1'b0, 4'b0100, 4'b0100, 8'h00};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL mrst_drop: got %h expected %h", obs, exp); end
      tick();
   endtask

   initial begin
      test_reset();
      test_max_burst();
      test_last_beat();
      test_stall();
      test_abandon();
      test_round_robin();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
